fsk_tone_ctrl: RTL and testbench

Symbol scheduler for the FSK transmitter. It accepts data bits over a valid/ready handshake and holds each bit for a fixed symbol period. During that period it drives a programmable half-period divider that toggles the tone output at the mark rate for a 1 bit and at the space rate for a 0 bit. It sits between the bit source and the FSK output stage, and it replaces fixed-ratio clock division with per-symbol rate selection.

---
 rtl/fsk_pkg.sv | 30 +++
 rtl/fsk_tone_div.sv | 60 ++++++
 rtl/fsk_tone_ctrl.sv | 135 +++++++++++++
 tb/tb_fsk_tone_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK tone controller.
// Holds the scheduler state type, the default rate and symbol constants,
// and a helper that picks the half-period terminal count for a bit value.
package fsk_pkg;

    // Scheduler states: no symbol on air, or a symbol being transmitted.
    typedef enum logic [0:0] {
        FSK_IDLE = 1'b0,
        FSK_TONE = 1'b1
    } fsk_state_e;

    localparam int FSK_MARK_DIV   = 32'sd8;
    localparam int FSK_SPACE_DIV  = 32'sd16;
    localparam int FSK_SYM_CYCLES = 32'sd1024;

    // Terminal value of the half-period counter for the given bit.
    // A mark (1) uses the mark half-period, a space (0) the space half-period.
    function automatic int fsk_half_last(input logic cur_bit,
                                         input int   mark_div,
                                         input int   space_div);
        int div_v;
        if (cur_bit) begin
            div_v = mark_div;
        end else begin
            div_v = space_div;
        end
        return div_v - 32'sd1;
    endfunction

endpackage

// File: rtl/fsk_tone_div.sv
// Half-period divider for the FSK tone.
// Counts clock cycles up to a programmable terminal value and toggles the
// tone flop each time the terminal value is reached. A clear forces the
// tone low and restarts the count; a load restarts the count but keeps
// the tone level, so consecutive symbols stay phase continuous.
module fsk_tone_div
    import fsk_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div_last,
    output logic             o_tone_out
);

    logic [DIV_W-1:0] r_half_cnt;
    logic             r_tone;
    logic             w_at_term;

    // Detect the last cycle of the current half-period.
    always_comb begin
        w_at_term = 1'b0;
        if (r_half_cnt == i_div_last) begin
            w_at_term = 1'b1;
        end else begin
            w_at_term = 1'b0;
        end
    end

    // Half-period counter and tone flop; toggle rule applies even on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half_cnt <= {DIV_W{1'b0}};
            r_tone     <= 1'b0;
        end else if (i_clr) begin
            r_half_cnt <= {DIV_W{1'b0}};
            r_tone     <= 1'b0;
        end else if (i_en) begin
            if (w_at_term) begin
                r_half_cnt <= {DIV_W{1'b0}};
                r_tone     <= ~r_tone;
            end else if (i_load) begin
                r_half_cnt <= {DIV_W{1'b0}};
            end else begin
                r_half_cnt <= r_half_cnt + DIV_W'(1'b1);
            end
        end else if (i_load) begin
            r_half_cnt <= {DIV_W{1'b0}};
        end else begin
            r_half_cnt <= r_half_cnt;
        end
    end

    assign o_tone_out = r_tone;

endmodule

// File: rtl/fsk_tone_ctrl.sv
// FSK symbol scheduler.
// Accepts one data bit per symbol over a valid/ready handshake, holds it
// for SYM_CYCLES clocks and drives the tone divider at the mark or space
// rate for that bit. A ready is offered in IDLE and on the final cycle of
// a symbol, which lets a waiting source chain symbols with no gap.
// Abort acts as a synchronous soft reset of the scheduler.
module fsk_tone_ctrl
    import fsk_pkg::*;
#(
    parameter int MARK_DIV   = FSK_MARK_DIV,
    parameter int SPACE_DIV  = FSK_SPACE_DIV,
    parameter int DIV_W      = 8,
    parameter int SYM_CYCLES = FSK_SYM_CYCLES,
    parameter int SYM_W      = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_bit_valid,
    input  logic i_bit_data,
    output logic o_bit_ready,
    input  logic i_abort,
    output logic o_tone_out,
    output logic o_tone_en,
    output logic o_sym_strobe,
    output logic o_busy
);

    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_CYCLES - 32'sd1);

    fsk_state_e       r_state;
    logic             r_cur_bit;
    logic [SYM_W-1:0] r_sym_cnt;
    logic             r_tone_en;
    logic             r_busy;
    logic             r_sym_strobe;

    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_div_clr;
    logic             w_div_en;
    logic [SYM_W-1:0] w_sym_next;
    logic [DIV_W-1:0] w_div_last;

    // Handshake and symbol-boundary decode.
    always_comb begin
        w_last   = 1'b0;
        w_ready  = 1'b0;
        w_accept = 1'b0;
        if ((r_state == FSK_TONE) && (r_sym_cnt == SYM_LAST)) begin
            w_last = 1'b1;
        end else begin
            w_last = 1'b0;
        end
        if (!i_abort && ((r_state == FSK_IDLE) || w_last)) begin
            w_ready = 1'b1;
        end else begin
            w_ready = 1'b0;
        end
        w_accept = i_bit_valid && w_ready;
    end

    // Divider control: run while a symbol is on air, clear when it stops.
    always_comb begin
        w_div_en  = 1'b0;
        w_div_clr = 1'b0;
        if (r_state == FSK_TONE) begin
            w_div_en = 1'b1;
        end else begin
            w_div_en = 1'b0;
        end
        if (i_abort || (w_last && !w_accept)) begin
            w_div_clr = 1'b1;
        end else begin
            w_div_clr = 1'b0;
        end
    end

    assign w_sym_next = r_sym_cnt + SYM_W'(1'b1);
    assign w_div_last = DIV_W'(fsk_half_last(r_cur_bit, MARK_DIV, SPACE_DIV));

    // Scheduler FSM, symbol counter and end-of-symbol strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FSK_IDLE;
            r_cur_bit    <= 1'b0;
            r_sym_cnt    <= {SYM_W{1'b0}};
            r_tone_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_sym_strobe <= 1'b0;
        end else if (i_abort) begin
            r_state      <= FSK_IDLE;
            r_sym_cnt    <= {SYM_W{1'b0}};
            r_tone_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_sym_strobe <= 1'b0;
        end else if (w_accept) begin
            r_state      <= FSK_TONE;
            r_cur_bit    <= i_bit_data;
            r_sym_cnt    <= {SYM_W{1'b0}};
            r_tone_en    <= 1'b1;
            r_busy       <= 1'b1;
            r_sym_strobe <= 1'b0;
        end else if (w_last) begin
            r_state      <= FSK_IDLE;
            r_sym_cnt    <= {SYM_W{1'b0}};
            r_tone_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_sym_strobe <= 1'b0;
        end else if (r_state == FSK_TONE) begin
            r_sym_cnt    <= w_sym_next;
            r_sym_strobe <= (w_sym_next == SYM_LAST);
        end else begin
            r_sym_strobe <= 1'b0;
        end
    end

    fsk_tone_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_div_en),
        .i_clr      (w_div_clr),
        .i_load     (w_accept),
        .i_div_last (w_div_last),
        .o_tone_out (o_tone_out)
    );

    assign o_bit_ready  = w_ready;
    assign o_tone_en    = r_tone_en;
    assign o_busy       = r_busy;
    assign o_sym_strobe = r_sym_strobe;

endmodule

// File: tb/tb_fsk_tone_ctrl.sv
// Self-checking bench for fsk_tone_ctrl with a cycle-level behavioural model.
module tb_fsk_tone_ctrl;

    localparam int MD = 2;
    localparam int SD = 4;
    localparam int SC = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic v     = 1'b0;
    logic d     = 1'b0;
    logic a     = 1'b0;
    logic ready, tone, en, strobe, busy;

    fsk_tone_ctrl #(
        .MARK_DIV(MD), .SPACE_DIV(SD), .DIV_W(8), .SYM_CYCLES(SC), .SYM_W(12)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bit_valid  (v),
        .i_bit_data   (d),
        .o_bit_ready  (ready),
        .i_abort      (a),
        .o_tone_out   (tone),
        .o_tone_en    (en),
        .o_sym_strobe (strobe),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: symbol active flag, elapsed cycles in symbol, held bit, tone level.
    bit m_active, m_bit, m_tone;
    int m_e;

    // Per-scenario observation counters.
    int  n_en, n_strobe, n_tog, n_ready;
    bit  prev_tone;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_e = 0; m_bit = 1'b0; m_tone = 1'b0;
    endtask

    function automatic bit m_ready(input bit aa);
        return !aa && (!m_active || (m_e == SC - 1));
    endfunction

    // Advance the model by one rising edge with the inputs seen at that edge.
    task automatic model_edge(input bit vv, input bit dd, input bit aa);
        bit acc;
        int div;
        acc = vv && m_ready(aa);
        div = m_bit ? MD : SD;
        if (aa) begin
            m_active = 1'b0; m_tone = 1'b0; m_e = 0;
        end else if (m_active) begin
            if (((m_e + 1) % div) == 0) m_tone = !m_tone;
            if (m_e == SC - 1) begin
                if (acc) begin
                    m_e = 0; m_bit = dd;
                end else begin
                    m_active = 1'b0; m_tone = 1'b0; m_e = 0;
                end
            end else begin
                m_e = m_e + 1;
            end
        end else if (acc) begin
            m_active = 1'b1; m_e = 0; m_bit = dd;
        end
    endtask

    task automatic clear_counts();
        n_en = 0; n_strobe = 0; n_tog = 0; n_ready = 0; prev_tone = tone;
    endtask

    // One clock: drive inputs, compare every output against the model, then take the edge.
    task automatic step(input bit vv, input bit dd, input bit aa);
        @(negedge clk);
        v = vv; d = dd; a = aa;
        #1;
        chk("tone_out",   tone,   m_tone);
        chk("tone_en",    en,     m_active);
        chk("busy",       busy,   m_active);
        chk("sym_strobe", strobe, m_active && (m_e == SC - 1));
        chk("bit_ready",  ready,  m_ready(aa));
        if (en) n_en++;
        if (strobe) n_strobe++;
        if (tone != prev_tone) n_tog++;
        prev_tone = tone;
        if (ready && en) n_ready++;
        @(posedge clk);
        model_edge(vv, dd, aa);
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1'b1;

        // Idle with no valid: nothing moves, ready stays high.
        clear_counts();
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk_int("idle_en_cycles", n_en, 0);
        chk_int("idle_toggles",   n_tog, 0);

        // Single mark symbol.
        clear_counts();
        step(1'b1, 1'b1, 1'b0);
        repeat (17) step(1'b0, 1'b0, 1'b0);
        chk_int("mark_en_cycles", n_en, 16);
        chk_int("mark_strobes",   n_strobe, 1);
        chk_int("mark_changes",   n_tog, 8);
        chk_int("mark_ready_busy", n_ready, 1);

        // Single space symbol.
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        repeat (17) step(1'b0, 1'b0, 1'b0);
        chk_int("space_en_cycles", n_en, 16);
        chk_int("space_strobes",   n_strobe, 1);
        chk_int("space_changes",   n_tog, 4);

        // Back-to-back 1, 0, 1 with valid held high until the third accept.
        clear_counts();
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 49; k++) step(k < 32, k >= 16, 1'b0);
        chk_int("b2b_en_cycles", n_en, 48);
        chk_int("b2b_strobes",   n_strobe, 3);
        chk_int("b2b_changes",   n_tog, 20);
        chk_int("b2b_ready_busy", n_ready, 3);

        // Abort at cycle 7 with valid also high.
        clear_counts();
        step(1'b1, 1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("abort_en_lit",   en,   1'b0);
        chk("abort_tone_lit", tone, 1'b0);
        chk_int("abort_strobes", n_strobe, 0);
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Reset mid-symbol: outputs clear without a clock edge.
        step(1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tone",   tone,   1'b0);
        chk("rst_en",     en,     1'b0);
        chk("rst_strobe", strobe, 1'b0);
        chk("rst_busy",   busy,   1'b0);
        chk("rst_ready",  ready,  1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, $urandom % 2, ($urandom % 40) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
